// File: rtl/sfu_job_sched_pkg.sv
// Shared state encoding and default widths for the softmax SFU job scheduler.
package sfu_sched_pkg;

  localparam int SFU_ADDR_W = 7;
  localparam int SFU_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sfu_job_sched_if.sv
// Job request/grant bundle from the cluster controllers plus the SFU launch/done and status lines.
interface sfu_job_sched_if
  import sfu_sched_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int ADDR_W   = SFU_ADDR_W,
  parameter int LEN_W    = SFU_LEN_W
);

  logic [PORT_NUM-1:0]        job_req;
  logic [PORT_NUM*ADDR_W-1:0] job_addr;
  logic [PORT_NUM*LEN_W-1:0]  job_len;
  logic [PORT_NUM-1:0]        job_gnt;
  logic [PORT_NUM-1:0]        job_done;
  logic                       sfu_start;
  logic [ADDR_W-1:0]          sfu_rw_scache_addr;
  logic [LEN_W-1:0]           cfg_qkv_len;
  logic                       sfu_done;
  logic                       sched_busy;
  logic                       err_timeout;
  logic                       err_clr;

  modport master (
    input  job_req, job_addr, job_len, sfu_done, err_clr,
    output job_gnt, job_done, sfu_start, sfu_rw_scache_addr, cfg_qkv_len, sched_busy, err_timeout
  );

  modport slave (
    output job_req, job_addr, job_len, sfu_done, err_clr,
    input  job_gnt, job_done, sfu_start, sfu_rw_scache_addr, cfg_qkv_len, sched_busy, err_timeout
  );

endinterface

// File: rtl/sfu_job_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module sfu_rr_pick #(
  parameter int PORT_NUM = 4,
  localparam int IDX_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic [PORT_NUM-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [PORT_NUM-1:0] o_onehot,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_vld
);

  // Rotate so the pointer position lands on bit 0; the lowest set bit is then the winner.
  logic [PORT_NUM-1:0] w_rot;
  assign w_rot = PORT_NUM'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_idx    = '0;
    o_vld    = 1'b0;
    o_onehot = '0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + k) % PORT_NUM);
      end
    end
    if (o_vld) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/sfu_job_sched.sv
// Shares one softmax SFU among PORT_NUM requesters: round-robin grant, SFU launch, done routing.
// Optional WAIT watchdog with sticky err_timeout is compiled in with SFU_SCHED_TIMEOUT_EN.
module sfu_job_sched
  import sfu_sched_pkg::*;
#(
  parameter int PORT_NUM    = 4,
  parameter int ADDR_W      = SFU_ADDR_W,
  parameter int LEN_W       = SFU_LEN_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic             clk,
  input logic             rst_n,
  sfu_job_sched_if.master bus
);

  localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  sched_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, r_win, w_pick_idx;
  logic [PORT_NUM-1:0] w_pick_oh, w_win_oh, r_gnt, r_done;
  logic                w_pick_vld, w_arb, w_tmo, w_err, r_start;
  logic [ADDR_W-1:0]   r_addr, w_pick_addr;
  logic [LEN_W-1:0]    r_len, w_pick_len;

  sfu_rr_pick #(.PORT_NUM(PORT_NUM)) u_pick (
    .i_req    (bus.job_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_vld    (w_pick_vld)
  );

  assign w_pick_addr = bus.job_addr[w_pick_idx*ADDR_W +: ADDR_W];
  assign w_pick_len  = bus.job_len[w_pick_idx*LEN_W +: LEN_W];
  assign w_win_oh    = {{(PORT_NUM-1){1'b0}}, 1'b1} << r_win;
  assign w_arb       = (r_state == ST_IDLE) && w_pick_vld && !w_err;

`ifdef SFU_SCHED_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  // Fires on the last permitted WAIT cycle, so RELEASE follows exactly as for a real sfu_done.
  assign w_tmo = (r_state == ST_WAIT) && !bus.sfu_done && (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));
  assign w_err = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (r_state == ST_WAIT) ? r_wdog + 1'b1 : '0;
      if (w_tmo)            r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_tmo        = 1'b0;
  assign w_err        = 1'b0;
  assign w_unused_cfg = ^{bus.err_clr, TIMEOUT_CYC[0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:  w_state_nxt = (r_len != '0) ? ST_WAIT : ST_RELEASE;
      ST_WAIT:    if (bus.sfu_done || w_tmo) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_gnt   <= '0;
      r_start <= 1'b0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_arb ? w_pick_oh : '0;
      r_start <= w_arb && (w_pick_len != '0);
      r_done  <= (w_state_nxt == ST_RELEASE) ? w_win_oh : '0;
      if (w_arb) begin
        r_win  <= w_pick_idx;
        r_addr <= w_pick_addr;
        r_len  <= w_pick_len;
      end
      if (r_state == ST_RELEASE)
        r_ptr <= (r_win == IDX_W'(PORT_NUM - 1)) ? '0 : r_win + 1'b1;
    end
  end

  assign bus.job_gnt            = r_gnt;
  assign bus.job_done           = r_done;
  assign bus.sfu_start          = r_start;
  assign bus.sfu_rw_scache_addr = r_addr;
  assign bus.cfg_qkv_len        = r_len;
  assign bus.sched_busy         = (r_state != ST_IDLE);
  assign bus.err_timeout        = w_err;

endmodule

// File: tb/tb_sfu_job_sched.sv
// Bench for sfu_job_sched: vector table, directed corner sequences, then randomized traffic vs a job-level model.
module tb_sfu_job_sched;

  localparam int PN = 4;
  localparam int AW = 7;
  localparam int LW = 8;
`ifdef SFU_SCHED_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [PN-1:0] p_req;
  logic [AW-1:0] p_addr [PN];
  logic [LW-1:0] p_len  [PN];

  sfu_job_sched_if #(.PORT_NUM(PN), .ADDR_W(AW), .LEN_W(LW)) bus ();

  sfu_job_sched #(.PORT_NUM(PN), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PN-1:0] req;
    logic          sd;
    logic [PN-1:0] gnt;
    logic          st;
    logic [PN-1:0] done;
    logic          busy;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [PN-1:0] g, input logic s,
                          input logic [PN-1:0] d, input logic b);
    chk({tag, ".gnt"},   32'(bus.job_gnt),    32'(g));
    chk({tag, ".start"}, 32'(bus.sfu_start),  32'(s));
    chk({tag, ".done"},  32'(bus.job_done),   32'(d));
    chk({tag, ".busy"},  32'(bus.sched_busy), 32'(b));
  endtask

  task automatic chk_al(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l);
    chk({tag, ".addr"}, 32'(bus.sfu_rw_scache_addr), 32'(a));
    chk({tag, ".len"},  32'(bus.cfg_qkv_len),        32'(l));
  endtask

  task automatic drive(input logic sd);
    for (int p = 0; p < PN; p++) begin
      bus.job_addr[p*AW +: AW] = p_addr[p];
      bus.job_len[p*LW +: LW]  = p_len[p];
    end
    bus.job_req  = p_req;
    bus.sfu_done = sd;
  endtask

  task automatic do_reset();
    p_req       = '0;
    bus.err_clr = 1'b0;
    drive(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Job-level reference: tracks when the scheduler is free, the rr pointer and the job in flight.
  task automatic run_random(input int ncyc);
    int t_free, sfu_due, zl_cycle, m_ptr, m_win;
    int gap [PN];
    logic [PN-1:0] e_gnt, e_done;
    logic e_start, sd, in_launch, in_rel, waiting, found;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    t_free = 0; sfu_due = -1; zl_cycle = -1; m_ptr = 0; m_win = 0;
    e_gnt = '0; e_done = '0; e_start = 1'b0; waiting = 1'b0;
    m_addr = '0; m_len = '0;
    for (int p = 0; p < PN; p++) gap[p] = 0;
    p_req = '0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk_outs("rnd", e_gnt, e_start, e_done, n < t_free);
      chk("rnd.err", 32'(bus.err_timeout), 32'd0);
      if (n < t_free) chk_al("rnd", m_addr, m_len);
      in_launch = (e_gnt != '0);
      in_rel    = (e_done != '0);
      for (int p = 0; p < PN; p++) begin
        if (e_gnt[p]) begin
          p_req[p] = 1'b0;
          gap[p]   = int'($urandom_range(0, 4));
        end else if (!p_req[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if ($urandom_range(0, 2) == 0) begin
            p_req[p]  = 1'b1;
            p_addr[p] = AW'($urandom);
            p_len[p]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 255));
          end
        end
      end
      if (e_start) sfu_due = n + int'($urandom_range(1, 12));
      sd = 1'b0;
      if (n == sfu_due) sd = 1'b1;
      else if ((n >= t_free || in_launch || in_rel) && $urandom_range(0, 7) == 0) sd = 1'b1;
      e_gnt = '0; e_start = 1'b0; e_done = '0;
      if (waiting && sd && !in_launch) begin
        e_done  = PN'(1) << m_win;
        waiting = 1'b0;
        sfu_due = -1;
        t_free  = n + 2;
      end
      if (n + 1 == zl_cycle) e_done = PN'(1) << m_win;
      if (n >= t_free && p_req != '0) begin
        found = 1'b0;
        for (int k = 0; k < PN; k++)
          if (!found && p_req[(m_ptr + k) % PN]) begin
            found = 1'b1;
            m_win = (m_ptr + k) % PN;
          end
        e_gnt  = PN'(1) << m_win;
        m_addr = p_addr[m_win];
        m_len  = p_len[m_win];
        m_ptr  = (m_win + 1) % PN;
        if (m_len != '0) begin
          e_start = 1'b1;
          waiting = 1'b1;
          t_free  = 1 << 30;
        end else begin
          zl_cycle = n + 2;
          t_free   = n + 3;
        end
      end
      drive(sd);
    end
    p_req = '0;
    drive(1'b0);
  endtask

  initial begin
    int got;
    // row inputs apply for one cycle; expected values are the outputs in the following cycle
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'h00, 8'd0};
    tbl[1]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 7'h22, 8'd0};
    tbl[2]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 7'h22, 8'd0};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'h00, 8'd0};
    tbl[4]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 7'h15, 8'd5};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'h15, 8'd5};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'h15, 8'd5};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 7'h15, 8'd5};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'h00, 8'd0};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 7'h01, 8'd1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'h01, 8'd1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1, 7'h01, 8'd1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'h00, 8'd0};
    p_addr[0] = 7'h01; p_len[0] = 8'd1;
    p_addr[1] = 7'h22; p_len[1] = 8'd0;
    p_addr[2] = 7'h15; p_len[2] = 8'd5;
    p_addr[3] = 7'h7F; p_len[3] = 8'd255;

    do_reset();
    @(negedge clk);
    chk_outs("reset", '0, 1'b0, '0, 1'b0);
    chk_al("reset", '0, '0);
    chk("reset.err", 32'(bus.err_timeout), 32'd0);

    for (int i = 0; i < 13; i++) begin
      p_req = tbl[i].req;
      drive(tbl[i].sd);
      @(negedge clk);
      chk_outs($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].st, tbl[i].done, tbl[i].busy);
      if (tbl[i].busy) chk_al($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].len);
    end

    // single job, sfu_done 40 cycles after the launch
    p_addr[2] = 7'h15; p_len[2] = 8'd16; p_req = 4'b0100;
    drive(1'b0);
    @(negedge clk);
    chk_outs("single.launch", 4'b0100, 1'b1, '0, 1'b1);
    chk_al("single.launch", 7'h15, 8'd16);
    p_req = '0;
    drive(1'b0);
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      chk_outs("single.wait", '0, 1'b0, '0, 1'b1);
      chk_al("single.wait", 7'h15, 8'd16);
    end
    @(negedge clk);
    chk_outs("single.wait40", '0, 1'b0, '0, 1'b1);
    drive(1'b1);
    @(negedge clk);
    chk_outs("single.done", '0, 1'b0, 4'b0100, 1'b1);
    drive(1'b0);
    @(negedge clk);
    chk_outs("single.idle", '0, 1'b0, '0, 1'b0);

    // reset while in WAIT, then rr pointer must restart at 0
    p_addr[3] = 7'h33; p_len[3] = 8'd8; p_req = 4'b1000;
    drive(1'b0);
    @(negedge clk);
    chk_outs("rstw.launch", 4'b1000, 1'b1, '0, 1'b1);
    p_req = '0;
    drive(1'b0);
    repeat (2) @(negedge clk);
    chk("rstw.inwait", 32'(bus.sched_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outs("rstw.async", '0, 1'b0, '0, 1'b0);
    chk_al("rstw.async", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    p_len[1] = 8'd0; p_req = 4'b1010;
    drive(1'b0);
    @(negedge clk);
    chk_outs("rstw.gnt1", 4'b0010, 1'b0, '0, 1'b1);
    p_req = 4'b1000;
    drive(1'b0);
    @(negedge clk);
    chk_outs("rstw.done1", '0, 1'b0, 4'b0010, 1'b1);
    @(negedge clk);
    chk_outs("rstw.idle", '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk_outs("rstw.gnt3", 4'b1000, 1'b1, '0, 1'b1);
    chk_al("rstw.gnt3", 7'h33, 8'd8);
    p_req = '0;
    drive(1'b0);
    @(negedge clk);
    drive(1'b1);
    @(negedge clk);
    chk_outs("rstw.done3", '0, 1'b0, 4'b1000, 1'b1);
    drive(1'b0);

    // fairness with every request held high
    do_reset();
    for (int p = 0; p < PN; p++) p_len[p] = '0;
    p_req = 4'b1111;
    drive(1'b0);
    for (int g = 0; g < 5; g++) begin
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        if (bus.job_gnt != '0) got = 1;
      end
      chk($sformatf("fair.seen%0d", g), 32'(got), 32'd1);
      if (got == 1) chk($sformatf("fair.order%0d", g), 32'(bus.job_gnt), 32'(1 << (g % 4)));
    end
    p_req = '0;
    drive(1'b0);

`ifdef SFU_SCHED_TIMEOUT_EN
    do_reset();
    p_len[0] = 8'd4; p_req = 4'b0001;
    drive(1'b0);
    @(negedge clk);
    chk_outs("tmo.launch", 4'b0001, 1'b1, '0, 1'b1);
    p_req = '0;
    drive(1'b0);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      chk("tmo.wait.done", 32'(bus.job_done), 32'd0);
      chk("tmo.wait.err", 32'(bus.err_timeout), 32'd0);
    end
    @(negedge clk);
    chk("tmo.done", 32'(bus.job_done), 32'b0001);
    chk("tmo.err", 32'(bus.err_timeout), 32'd1);
    p_len[1] = 8'd0; p_req = 4'b0010;
    drive(1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("tmo.blocked", 32'(bus.job_gnt), 32'd0);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("tmo.errclr", 32'(bus.err_timeout), 32'd0);
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      @(negedge clk);
      if (bus.job_gnt != '0) got = 1;
    end
    chk("tmo.regrant.seen", 32'(got), 32'd1);
    chk("tmo.regrant", 32'(bus.job_gnt), 32'b0010);
    p_req = '0;
    drive(1'b0);
`endif

    do_reset();
    run_random(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
